// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: PPU > clear-fill > debug, with a registered write port.
// Define FB_ARB_DBG_EN to enable the debug write port; otherwise it is never granted.
module fb_write_arbiter #(
    parameter int unsigned FB_WORDS = 23040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppu_we,
    input  logic [14:0] ppu_addr,
    input  logic [1:0]  ppu_color,
    input  logic        clr_start,
    input  logic [1:0]  clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    input  logic        dbg_valid,
    input  logic [14:0] dbg_addr,
    input  logic [1:0]  dbg_color,
    output logic        dbg_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [1:0]  fb_din,
    output logic [1:0]  grant
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] G_NONE  = 2'b00;
    localparam logic [1:0] G_PPU   = 2'b01;
    localparam logic [1:0] G_CLEAR = 2'b10;
    localparam logic [1:0] G_DBG   = 2'b11;

    localparam logic [14:0] LP_LAST  = 15'(FB_WORDS - 1);
    localparam logic [15:0] LP_WORDS = 16'(FB_WORDS);

    logic [1:0]  r_state;
    logic [14:0] r_cnt;
    logic [1:0]  r_clr_color;
    logic        r_fb_we;
    logic [14:0] r_fb_addr;
    logic [1:0]  r_fb_din;
    logic [1:0]  r_grant;

    logic        w_dbg_ready;
    logic [1:0]  w_grant;
    logic [14:0] w_addr;
    logic [1:0]  w_din;
    logic        w_clr_win;
    logic        w_in_range;

`ifdef FB_ARB_DBG_EN
    assign w_dbg_ready = ~ppu_we & (r_state != S_CLEAR);
`else
    assign w_dbg_ready = 1'b0;
`endif

    always_comb begin
        w_grant = G_NONE;
        w_addr  = '0;
        w_din   = '0;
        if (ppu_we) begin
            w_grant = G_PPU;
            w_addr  = ppu_addr;
            w_din   = ppu_color;
        end else if (r_state == S_CLEAR) begin
            w_grant = G_CLEAR;
            w_addr  = r_cnt;
            w_din   = r_clr_color;
        end else if (dbg_valid & w_dbg_ready) begin
            w_grant = G_DBG;
            w_addr  = dbg_addr;
            w_din   = dbg_color;
        end
    end

    assign w_clr_win  = (w_grant == G_CLEAR);
    assign w_in_range = ({1'b0, w_addr} < LP_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_clr_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state     <= S_CLEAR;
                        r_cnt       <= '0;
                        r_clr_color <= clr_color;
                    end
                end
                S_CLEAR: begin
                    // Counter only advances when the fill actually owns the write port.
                    if (w_clr_win) begin
                        r_cnt <= r_cnt + 15'd1;
                        if (r_cnt == LP_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_din  <= '0;
            r_grant   <= G_NONE;
        end else begin
            r_fb_we   <= (w_grant != G_NONE) & w_in_range;
            r_fb_addr <= w_addr;
            r_fb_din  <= w_din;
            r_grant   <= w_grant;
        end
    end

    assign clr_busy  = (r_state == S_CLEAR);
    assign clr_done  = (r_state == S_DONE);
    assign dbg_ready = w_dbg_ready;
    assign fb_we     = r_fb_we;
    assign fb_addr   = r_fb_addr;
    assign fb_din    = r_fb_din;
    assign grant     = r_grant;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed-vector bench for fb_write_arbiter: PPU, fills, contention, range, reset, debug.
module tb_fb_write_arbiter;

    localparam int FBW = 23040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ppu_we = 1'b0;
    logic [14:0] ppu_addr = '0;
    logic [1:0]  ppu_color = '0;
    logic        clr_start = 1'b0;
    logic [1:0]  clr_color = '0;
    logic        clr_busy;
    logic        clr_done;
    logic        dbg_valid = 1'b0;
    logic [14:0] dbg_addr = '0;
    logic [1:0]  dbg_color = '0;
    logic        dbg_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [1:0]  fb_din;
    logic [1:0]  grant;

    int n_vec = 0;
    int n_bad = 0;

    fb_write_arbiter #(.FB_WORDS(FBW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ppu_we    (ppu_we),
        .ppu_addr  (ppu_addr),
        .ppu_color (ppu_color),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .dbg_valid (dbg_valid),
        .dbg_addr  (dbg_addr),
        .dbg_color (dbg_color),
        .dbg_ready (dbg_ready),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_din    (fb_din),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one fill with a cycle-accurate expectation model; contend puts PPU writes
    // on even cycles, starting with the clr_start cycle itself.
    task automatic run_fill(input string tag, input logic [1:0] col, input bit contend,
                            input int min_cyc, input int max_cyc);
        int          m_cnt = 0;
        bit          m_clr = 0;
        bit          clr_w;
        int          bad = 0;
        int          done_cyc = -1;
        logic        pw;
        logic [14:0] pa;
        logic [1:0]  pc;
        for (int k = 0; k < 50000 && done_cyc < 0; k++) begin
            clr_start = (k == 0) || (k == 1000);
            clr_color = (k == 0) ? col : ~col;
            ppu_we    = contend && (k % 2 == 0);
            ppu_addr  = 15'((k * 7) % FBW);
            ppu_color = 2'(k);
            pw = ppu_we; pa = ppu_addr; pc = ppu_color; clr_w = m_clr;
            tick();
            if (pw) begin
                if (!(fb_we === 1'b1 && grant === 2'b01 && fb_addr === pa && fb_din === pc))
                    bad++;
            end else if (clr_w) begin
                if (!(fb_we === 1'b1 && grant === 2'b10 && 32'(fb_addr) == m_cnt
                      && fb_din === col))
                    bad++;
                m_cnt++;
                if (m_cnt == FBW) m_clr = 0;
            end else if (fb_we !== 1'b0 || grant !== 2'b00) begin
                bad++;
            end
            if (k == 0) m_clr = 1;
            if (clr_busy !== m_clr) bad++;
            if (clr_done === 1'b1) done_cyc = k + 1;
        end
        clr_start = 1'b0;
        ppu_we    = 1'b0;
        chk({tag, " write/busy errors"}, 32'(bad), 32'd0);
        chk({tag, " words cleared"}, 32'(m_cnt), 32'(FBW));
        chk({tag, " done within range"},
            32'(done_cyc >= min_cyc && done_cyc <= max_cyc), 32'd1);
        tick();
        chk({tag, " done single pulse"}, 32'(clr_done), 32'd0);
        chk({tag, " busy after done"}, 32'(clr_busy), 32'd0);
    endtask

    initial begin
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset fb_we", 32'(fb_we), 32'd0);
        chk("reset fb_addr", 32'(fb_addr), 32'd0);
        chk("reset fb_din", 32'(fb_din), 32'd0);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset clr_busy", 32'(clr_busy), 32'd0);
        chk("reset clr_done", 32'(clr_done), 32'd0);

        ppu_we = 1'b1; ppu_addr = 15'd100; ppu_color = 2'd3;
        tick();
        ppu_we = 1'b0;
        chk("ppu fb_we", 32'(fb_we), 32'd1);
        chk("ppu fb_addr", 32'(fb_addr), 32'd100);
        chk("ppu fb_din", 32'(fb_din), 32'd3);
        chk("ppu grant", 32'(grant), 32'd1);
        tick();
        chk("idle grant", 32'(grant), 32'd0);
        chk("idle fb_we", 32'(fb_we), 32'd0);

        ppu_we = 1'b1; ppu_addr = 15'd23040; ppu_color = 2'd1;
        tick();
        chk("oor grant", 32'(grant), 32'd1);
        chk("oor fb_we", 32'(fb_we), 32'd0);
        ppu_addr = 15'd23039;
        tick();
        ppu_we = 1'b0;
        chk("last addr fb_we", 32'(fb_we), 32'd1);
        chk("last addr fb_addr", 32'(fb_addr), 32'd23039);

        run_fill("idle fill", 2'd2, 1'b0, 23041, 23041);
        run_fill("contended fill", 2'd1, 1'b1, 46079, 46080);

        clr_start = 1'b1; clr_color = 2'd1;
        tick();
        clr_start = 1'b0;
        repeat (5000) tick();
        chk("midfill addr before reset", 32'(fb_addr), 32'd4999);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst fb_we", 32'(fb_we), 32'd0);
        chk("midrst fb_addr", 32'(fb_addr), 32'd0);
        chk("midrst fb_din", 32'(fb_din), 32'd0);
        chk("midrst grant", 32'(grant), 32'd0);
        chk("midrst clr_busy", 32'(clr_busy), 32'd0);
        chk("midrst clr_done", 32'(clr_done), 32'd0);
        tick();
        chk("post rst clr_done", 32'(clr_done), 32'd0);
        chk("post rst grant", 32'(grant), 32'd0);
        clr_start = 1'b1; clr_color = 2'd3;
        tick();
        clr_start = 1'b0;
        tick();
        chk("restart addr", 32'(fb_addr), 32'd0);
        chk("restart din", 32'(fb_din), 32'd3);
        chk("restart grant", 32'(grant), 32'd2);
        tick();
        chk("restart next addr", 32'(fb_addr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef FB_ARB_DBG_EN
        ppu_we = 1'b1; ppu_addr = 15'd10; ppu_color = 2'd2;
        dbg_valid = 1'b1; dbg_addr = 15'd20; dbg_color = 2'd1;
        #1;
        chk("dbg ready under ppu", 32'(dbg_ready), 32'd0);
        tick();
        chk("dbg blocked grant", 32'(grant), 32'd1);
        ppu_we = 1'b0;
        #1;
        chk("dbg ready idle", 32'(dbg_ready), 32'd1);
        tick();
        dbg_valid = 1'b0;
        chk("dbg grant", 32'(grant), 32'd3);
        chk("dbg fb_addr", 32'(fb_addr), 32'd20);
        chk("dbg fb_din", 32'(fb_din), 32'd1);
        chk("dbg fb_we", 32'(fb_we), 32'd1);
`else
        dbg_valid = 1'b1; dbg_addr = 15'd20; dbg_color = 2'd1;
        #1;
        chk("dbg ready disabled", 32'(dbg_ready), 32'd0);
        tick();
        dbg_valid = 1'b0;
        chk("dbg disabled grant", 32'(grant), 32'd0);
        chk("dbg disabled fb_we", 32'(fb_we), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
